// File: rtl/dvp_tx_pkg.sv
// Shared definitions for the DVP transmit path: FSM state encoding,
// RGB565 colour-bar constants and a counter-width helper.
package dvp_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } tx_state_t;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    // Width of a counter that must hold 0..n-1; never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Colour of vertical bar idx, left to right.
    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/dvp_stream_tx_if.sv
// Valid/ready pixel stream feeding the DVP transmitter.
// master = pixel producer, slave = the transmitter.
interface dvp_stream_tx_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/dvp_timing_gen.sv
// Free-running frame timing for the DVP transmitter: horizontal/vertical
// counters plus the frame FSM. All outputs are registered and describe the
// current cycle's position (computed from the next-state values).
module dvp_timing_gen
    import dvp_tx_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 160,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic pclk,
    input  logic rst,
    input  logic enable,
    output logic line_active,
    output logic vsync_raw,
    output logic frame_start_raw
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_MAX01 = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int V_MAX23 = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int V_MAX   = (V_MAX01 > V_MAX23) ? V_MAX01 : V_MAX23;
    localparam int HW      = cnt_w(H_TOTAL);
    localparam int VW      = cnt_w(V_MAX);

    tx_state_t     state;
    tx_state_t     nxt_state;
    logic [HW-1:0] hcnt;
    logic [HW-1:0] nxt_hcnt;
    logic [VW-1:0] vcnt;
    logic [VW-1:0] nxt_vcnt;
    logic [VW-1:0] last_line;
    logic          line_end;

    assign line_end = (hcnt == HW'(H_TOTAL - 1));

    // Index of the final line of the current vertical region.
    always_comb begin
        last_line = '0;
        case (state)
            ST_VSYNC:  last_line = VW'(VSYNC_LINES - 1);
            ST_VBACK:  last_line = VW'(V_BACK - 1);
            ST_ACTIVE: last_line = VW'(V_ACTIVE - 1);
            ST_VFRONT: last_line = VW'(V_FRONT - 1);
            default:   last_line = '0;
        endcase
    end

    // Next position: hcnt wraps every line, vcnt wraps per region, and the
    // region advances on the last pixel of its last line. enable is only
    // looked at while idle or at the very end of the front porch.
    always_comb begin
        nxt_state = state;
        nxt_hcnt  = hcnt;
        nxt_vcnt  = vcnt;
        if (state == ST_IDLE) begin
            nxt_hcnt = '0;
            nxt_vcnt = '0;
            if (enable) begin
                nxt_state = ST_VSYNC;
            end
        end else if (!line_end) begin
            nxt_hcnt = hcnt + HW'(1);
        end else begin
            nxt_hcnt = '0;
            if (vcnt != last_line) begin
                nxt_vcnt = vcnt + VW'(1);
            end else begin
                nxt_vcnt = '0;
                case (state)
                    ST_VSYNC:  nxt_state = ST_VBACK;
                    ST_VBACK:  nxt_state = ST_ACTIVE;
                    ST_ACTIVE: nxt_state = ST_VFRONT;
                    ST_VFRONT: nxt_state = enable ? ST_VSYNC : ST_IDLE;
                    default:   nxt_state = ST_IDLE;
                endcase
            end
        end
    end

    // Frame FSM and counters, with the position flags registered alongside.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            hcnt            <= '0;
            vcnt            <= '0;
            line_active     <= 1'b0;
            vsync_raw       <= 1'b0;
            frame_start_raw <= 1'b0;
        end else begin
            state           <= nxt_state;
            hcnt            <= nxt_hcnt;
            vcnt            <= nxt_vcnt;
            line_active     <= (nxt_state == ST_ACTIVE) && (nxt_hcnt < HW'(H_ACTIVE));
            vsync_raw       <= (nxt_state == ST_VSYNC);
            frame_start_raw <= (nxt_state == ST_VSYNC) && (nxt_hcnt == '0) && (nxt_vcnt == '0);
        end
    end

endmodule

// File: rtl/dvp_stream_tx.sv
// DVP transmitter top: converts a valid/ready RGB565 pixel stream into
// camera-style href/vsync/data timing. Timing never waits for upstream;
// a missing pixel in an active slot is replaced by FILL and flagged.
// Optional feature macro: DVP_TX_PATTERN_EN adds input pattern_on, which
// replaces the stream with eight vertical colour bars for a whole frame.
module dvp_stream_tx
    import dvp_tx_pkg::*;
#(
    parameter int              DATA_W      = 16,
    parameter int              H_ACTIVE    = 640,
    parameter int              H_BLANK     = 160,
    parameter int              V_ACTIVE    = 480,
    parameter int              VSYNC_LINES = 3,
    parameter int              V_BACK      = 17,
    parameter int              V_FRONT     = 10,
    parameter logic [DATA_W-1:0] FILL      = '0
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              enable,
`ifdef DVP_TX_PATTERN_EN
    input  logic              pattern_on,
`endif
    dvp_stream_tx_if.slave    pix,
    output logic              cmos_href,
    output logic              cmos_vsync,
    output logic [DATA_W-1:0] cmos_data,
    output logic              frame_start,
    output logic              underrun
);

    logic              line_active;
    logic              vsync_raw;
    logic              frame_start_raw;
    logic              stream_en;
    logic [DATA_W-1:0] slot_pixel;

    dvp_timing_gen #(
        .H_ACTIVE    (H_ACTIVE),
        .H_BLANK     (H_BLANK),
        .V_ACTIVE    (V_ACTIVE),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT)
    ) u_timing (
        .pclk            (pclk),
        .rst             (rst),
        .enable          (enable),
        .line_active     (line_active),
        .vsync_raw       (vsync_raw),
        .frame_start_raw (frame_start_raw)
    );

`ifdef DVP_TX_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = cnt_w(BAR_W);

    logic          pattern_mode;
    logic [BW-1:0] bar_pos;
    logic [2:0]    bar_idx;

    // Pattern selection is frozen for a whole frame, taken at its first cycle.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            pattern_mode <= 1'b0;
        end else if (frame_start_raw) begin
            pattern_mode <= pattern_on;
        end
    end

    // Tracks which bar the current active slot falls in; restarts every line.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            bar_pos <= '0;
            bar_idx <= '0;
        end else if (!line_active) begin
            bar_pos <= '0;
            bar_idx <= '0;
        end else if (bar_pos == BW'(BAR_W - 1)) begin
            bar_pos <= '0;
            if (bar_idx != 3'd7) begin
                bar_idx <= bar_idx + 3'd1;
            end
        end else begin
            bar_pos <= bar_pos + BW'(1);
        end
    end

    assign stream_en  = !pattern_mode;
    assign slot_pixel = pattern_mode ? DATA_W'(bar_colour(bar_idx))
                                     : (pix.valid ? pix.data : FILL);
`else
    assign stream_en  = 1'b1;
    assign slot_pixel = pix.valid ? pix.data : FILL;
`endif

    assign pix.ready = line_active & stream_en;

    // Output stage: everything lags the slot decision by exactly one cycle.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            cmos_href   <= 1'b0;
            cmos_vsync  <= 1'b0;
            cmos_data   <= '0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            cmos_href   <= line_active;
            cmos_vsync  <= vsync_raw;
            cmos_data   <= line_active ? slot_pixel : '0;
            frame_start <= frame_start_raw;
            underrun    <= line_active & stream_en & !pix.valid;
        end
    end

endmodule

// File: tb/tb_dvp_stream_tx.sv
// Self-checking bench for dvp_stream_tx using a small frame geometry
// (84 cycles per frame). Expected outputs come from a position-in-frame
// model plus a pixel queue. Define DVP_TX_PATTERN_EN to also cover colour bars.
module tb_dvp_stream_tx;

    localparam int H_ACTIVE    = 8;
    localparam int H_BLANK     = 4;
    localparam int V_ACTIVE    = 4;
    localparam int VSYNC_LINES = 1;
    localparam int V_BACK      = 1;
    localparam int V_FRONT     = 1;
    localparam int H_TOTAL     = H_ACTIVE + H_BLANK;
    localparam int FRAME       = (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT) * H_TOTAL;
    localparam logic [15:0] FILL = 16'h0000;

    logic        pclk = 1'b0;
    logic        rst;
    logic        enable;
    logic        pattern_on;
    logic        cmos_href;
    logic        cmos_vsync;
    logic [15:0] cmos_data;
    logic        frame_start;
    logic        underrun;

    dvp_stream_tx_if #(.DATA_W(16)) pix ();

    dvp_stream_tx #(
        .DATA_W      (16),
        .H_ACTIVE    (H_ACTIVE),
        .H_BLANK     (H_BLANK),
        .V_ACTIVE    (V_ACTIVE),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT),
        .FILL        (FILL)
    ) dut (
        .pclk        (pclk),
        .rst         (rst),
        .enable      (enable),
`ifdef DVP_TX_PATTERN_EN
        .pattern_on  (pattern_on),
`endif
        .pix         (pix),
        .cmos_href   (cmos_href),
        .cmos_vsync  (cmos_vsync),
        .cmos_data   (cmos_data),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    always #5 pclk = ~pclk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] drv_q[$];
    logic [15:0] mdl_q[$];
    logic [19:0] obs_vec;
    bit          obs_rdy;
    bit          obs_acc;
    logic [15:0] bar_tbl [0:7] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                   16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    // Position within the frame shown at the outputs after tick k, or -1.
    function automatic int phase(input int k, input int frames);
        if (k < 1 || (k - 1) >= frames * FRAME) return -1;
        return (k - 1) % FRAME;
    endfunction

    function automatic bit m_href(input int ph);
        int line;
        int col;
        if (ph < 0) return 1'b0;
        line = ph / H_TOTAL;
        col  = ph % H_TOTAL;
        return (line >= VSYNC_LINES + V_BACK) && (line < VSYNC_LINES + V_BACK + V_ACTIVE)
               && (col < H_ACTIVE);
    endfunction

    // Expected {href, vsync, frame_start, underrun, data} after tick k.
    task automatic model_out(input int k, input int frames, input bit v, input bit pat,
                             output logic [19:0] e);
        int          ph;
        bit          href;
        bit          vs;
        bit          fs;
        bit          ur;
        logic [15:0] d;
        ph   = phase(k, frames);
        href = m_href(ph);
        vs   = (ph >= 0) && (ph / H_TOTAL < VSYNC_LINES);
        fs   = (ph == 0);
        ur   = 1'b0;
        d    = 16'h0000;
        if (href) begin
            if (pat) begin
                d = bar_tbl[(ph % H_TOTAL) / (H_ACTIVE / 8)];
            end else if (v) begin
                d = (mdl_q.size() > 0) ? mdl_q.pop_front() : 16'hxxxx;
            end else begin
                d  = FILL;
                ur = 1'b1;
            end
        end
        e = {href, vs, fs, ur, d};
    endtask

    task automatic push_pixels(input int n, input bit ramp, input logic [15:0] base);
        logic [15:0] val;
        for (int i = 0; i < n; i++) begin
            val = ramp ? base + 16'(i) : 16'($urandom);
            drv_q.push_back(val);
            mdl_q.push_back(val);
        end
    endtask

    // One clock: drive inputs at the negedge, sample outputs 1 time unit
    // after the rising edge, return at the next negedge.
    task automatic tick(input bit v);
        pix.valid = v;
        pix.data  = (v && drv_q.size() > 0) ? drv_q[0] : 16'($urandom);
        #1;
        obs_rdy = pix.ready;
        obs_acc = obs_rdy & v;
        @(posedge pclk);
        #1;
        obs_vec = {cmos_href, cmos_vsync, frame_start, underrun, cmos_data};
        if (obs_acc && drv_q.size() > 0) void'(drv_q.pop_front());
        @(negedge pclk);
    endtask

    task automatic do_reset(input bit en, input bit pat);
        rst        = 1'b1;
        enable     = en;
        pattern_on = pat;
        pix.valid  = 1'b0;
        pix.data   = 16'h0000;
        drv_q.delete();
        mdl_q.delete();
        repeat (2) @(negedge pclk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        enable     = 1'b0;
        pattern_on = 1'b0;
        pix.valid  = 1'b1;
        pix.data   = 16'h1234;
        #2;
        checks++;
        if ({cmos_href, cmos_vsync, frame_start, underrun, cmos_data} !== 20'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h expected 00000",
                     {cmos_href, cmos_vsync, frame_start, underrun, cmos_data});
        end
        checks++;
        if (pix.ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready got %b expected 0", pix.ready);
        end
        do_reset(1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick(1'b1);
            checks++;
            if (obs_vec !== 20'h0 || obs_rdy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle_outputs k=%0d got %h/%b expected 00000/0", k, obs_vec, obs_rdy);
            end
        end
    endtask

    task automatic test_stream_frame();
        logic [19:0] e;
        int vs_fall = -1;
        int href_rise = -1;
        bit prev_vs = 1'b0;
        bit prev_href = 1'b0;
        do_reset(1'b1, 1'b0);
        push_pixels(40, 1'b1, 16'h0001);
        for (int k = 0; k <= FRAME; k++) begin
            bit exp_rdy;
            exp_rdy = m_href(phase(k, 1));
            tick(1'b1);
            model_out(k, 1, 1'b1, 1'b0, e);
            checks++;
            if (obs_rdy !== exp_rdy) begin
                errors++;
                $display("[TB] FAIL stream_ready k=%0d got %b expected %b", k, obs_rdy, exp_rdy);
            end
            checks++;
            if (obs_vec !== e) begin
                errors++;
                $display("[TB] FAIL stream_outputs k=%0d got %h expected %h", k, obs_vec, e);
            end
            if (prev_vs && !obs_vec[18] && vs_fall < 0) vs_fall = k;
            if (!prev_href && obs_vec[19] && href_rise < 0) href_rise = k;
            prev_vs   = obs_vec[18];
            prev_href = obs_vec[19];
        end
        checks++;
        if (href_rise - vs_fall !== V_BACK * H_TOTAL) begin
            errors++;
            $display("[TB] FAIL vsync_to_href got %0d expected %0d", href_rise - vs_fall, V_BACK * H_TOTAL);
        end
        checks++;
        if (drv_q.size() !== 40 - H_ACTIVE * V_ACTIVE) begin
            errors++;
            $display("[TB] FAIL stream_consumed got %0d expected %0d",
                     40 - drv_q.size(), H_ACTIVE * V_ACTIVE);
        end
    endtask

    task automatic test_underrun();
        localparam int UR_PH = (VSYNC_LINES + V_BACK) * H_TOTAL + 3;
        logic [19:0] e;
        logic [15:0] pushed [$];
        int href_line0 = 0;
        int ur_line0 = 0;
        do_reset(1'b1, 1'b0);
        push_pixels(40, 1'b0, 16'h0000);
        pushed = mdl_q;
        for (int k = 0; k <= FRAME; k++) begin
            bit v;
            int ph;
            ph = phase(k, 1);
            v  = 1'b1;
            if (ph == UR_PH) v = 1'b0;
            else if (ph >= UR_PH + H_TOTAL) v = ($urandom_range(0, 3) != 0);
            tick(v);
            model_out(k, 1, v, 1'b0, e);
            checks++;
            if (obs_vec !== e) begin
                errors++;
                $display("[TB] FAIL underrun_outputs k=%0d got %h expected %h", k, obs_vec, e);
            end
            if (ph >= UR_PH - 3 && ph < UR_PH - 3 + H_TOTAL) begin
                href_line0 += int'(obs_vec[19]);
                ur_line0   += int'(obs_vec[16]);
            end
            if (ph == UR_PH + 1) begin
                checks++;
                if (obs_vec[15:0] !== pushed[3]) begin
                    errors++;
                    $display("[TB] FAIL resume_pixel got %h expected %h", obs_vec[15:0], pushed[3]);
                end
            end
        end
        checks++;
        if (href_line0 !== H_ACTIVE) begin
            errors++;
            $display("[TB] FAIL underrun_line_len got %0d expected %0d", href_line0, H_ACTIVE);
        end
        checks++;
        if (ur_line0 !== 1) begin
            errors++;
            $display("[TB] FAIL underrun_pulses got %0d expected 1", ur_line0);
        end
    endtask

    task automatic test_enable_drop();
        logic [19:0] e;
        int fs_count = 0;
        do_reset(1'b1, 1'b0);
        push_pixels(40, 1'b1, 16'h0200);
        for (int k = 0; k <= FRAME + 2 * H_TOTAL; k++) begin
            bit exp_rdy;
            if (phase(k, 1) == (VSYNC_LINES + V_BACK + 2) * H_TOTAL + 3) enable = 1'b0;
            exp_rdy = m_href(phase(k, 1));
            tick(1'b1);
            model_out(k, 1, 1'b1, 1'b0, e);
            fs_count += int'(obs_vec[17]);
            checks++;
            if (obs_vec !== e || obs_rdy !== exp_rdy) begin
                errors++;
                $display("[TB] FAIL enable_drop k=%0d got %h/%b expected %h/%b", k, obs_vec, obs_rdy, e, exp_rdy);
            end
        end
        checks++;
        if (fs_count !== 1) begin
            errors++;
            $display("[TB] FAIL enable_drop_frames got %0d expected 1", fs_count);
        end
    endtask

    task automatic test_reset_mid_line();
        logic [19:0] e;
        do_reset(1'b1, 1'b0);
        push_pixels(40, 1'b1, 16'h0300);
        for (int k = 0; k <= 31; k++) tick(1'b1);
        checks++;
        if (obs_vec[19] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL href_before_reset got %b expected 1", obs_vec[19]);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({cmos_href, cmos_vsync, frame_start, underrun, cmos_data, pix.ready} !== 21'h0) begin
            errors++;
            $display("[TB] FAIL async_reset got %h expected 000000",
                     {cmos_href, cmos_vsync, frame_start, underrun, cmos_data, pix.ready});
        end
        @(negedge pclk);
        do_reset(1'b1, 1'b0);
        push_pixels(40, 1'b1, 16'h0400);
        for (int k = 0; k <= FRAME; k++) begin
            bit exp_rdy;
            exp_rdy = m_href(phase(k, 1));
            tick(1'b1);
            model_out(k, 1, 1'b1, 1'b0, e);
            checks++;
            if (obs_vec !== e || obs_rdy !== exp_rdy) begin
                errors++;
                $display("[TB] FAIL restart k=%0d got %h/%b expected %h/%b", k, obs_vec, obs_rdy, e, exp_rdy);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] e;
        int fs_at [$];
        int acc_per [3] = '{0, 0, 0};
        do_reset(1'b1, 1'b0);
        push_pixels(3 * H_ACTIVE * V_ACTIVE + 10, 1'b0, 16'h0000);
        for (int k = 0; k <= 3 * FRAME; k++) begin
            tick(1'b1);
            model_out(k, 4, 1'b1, 1'b0, e);
            checks++;
            if (obs_vec !== e) begin
                errors++;
                $display("[TB] FAIL b2b_outputs k=%0d got %h expected %h", k, obs_vec, e);
            end
            if (obs_vec[17]) fs_at.push_back(k);
            if (obs_acc && k >= 1) acc_per[(k - 1) / FRAME]++;
        end
        checks++;
        if (fs_at.size() !== 3) begin
            errors++;
            $display("[TB] FAIL b2b_frame_count got %0d expected 3", fs_at.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (fs_at[i] - fs_at[i-1] !== FRAME) begin
                    errors++;
                    $display("[TB] FAIL b2b_period got %0d expected %0d", fs_at[i] - fs_at[i-1], FRAME);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (acc_per[i] !== H_ACTIVE * V_ACTIVE) begin
                errors++;
                $display("[TB] FAIL b2b_accepted frame=%0d got %0d expected %0d", i, acc_per[i], H_ACTIVE * V_ACTIVE);
            end
        end
    endtask

`ifdef DVP_TX_PATTERN_EN
    task automatic test_pattern();
        logic [19:0] e;
        do_reset(1'b1, 1'b1);
        push_pixels(8, 1'b1, 16'h0500);
        for (int k = 0; k <= FRAME; k++) begin
            bit v;
            v = ($urandom_range(0, 1) != 0);
            tick(v);
            model_out(k, 1, v, 1'b1, e);
            checks++;
            if (obs_vec !== e || obs_rdy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL pattern k=%0d got %h/%b expected %h/0", k, obs_vec, obs_rdy, e);
            end
        end
        pattern_on = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_stream_frame();
        test_underrun();
        test_enable_drop();
        test_reset_mid_line();
        test_back_to_back();
`ifdef DVP_TX_PATTERN_EN
        test_pattern();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
